// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared flag indices, fill-state encoding and depth for the add/sub result stage
package addsub_pkg;

    localparam int ADDSUB_DEPTH = 2;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic [3:0] sum;
        logic [3:0] flags;
    } entry_t;

endpackage

// File: rtl/addsub_flag_gen.sv
// rtl/addsub_flag_gen.sv - combinational {N,Z,C,V} flag generation from adder/subtractor operands and result
module addsub_flag_gen
    import addsub_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       sel,
    input  logic [3:0] sum,
    input  logic       carry_out,
    output logic [3:0] flags
);

    logic [3:0] b_eff;

    // Flags derive from the operand actually seen by the adder (B inverted when subtracting)
    always_comb begin
        b_eff         = B ^ {4{sel}};
        flags         = 4'b0000;
        flags[FLAG_N] = sum[3];
        flags[FLAG_Z] = (sum == 4'd0);
        flags[FLAG_C] = carry_out;
        flags[FLAG_V] = (A[3] == b_eff[3]) && (sum[3] != A[3]);
    end

endmodule

// File: rtl/addsub_result_stage.sv
// rtl/addsub_result_stage.sv - two-entry result FIFO with flags, sticky overflow and accept counter
module addsub_result_stage
    import addsub_pkg::*;
#(
    parameter int DEPTH = ADDSUB_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       sel,
    input  logic [3:0] sum,
    input  logic       carry_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic [3:0] out_flags,
    output logic       sticky_v,
    input  logic       clr_sticky,
    output logic [7:0] op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

    fill_state_e state_q, state_d;
    entry_t      ent_q [DEPTH];
    entry_t      ent_d [DEPTH];
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    logic [7:0]  op_count_q, op_count_d;
    logic        sticky_q, sticky_d;

    logic [3:0]  new_flags;
    logic        push;
    logic        pop;

    addsub_flag_gen u_flag_gen (
        .A         (A),
        .B         (B),
        .sel       (sel),
        .sum       (sum),
        .carry_out (carry_out),
        .flags     (new_flags)
    );

    // Handshake decode; in_ready comes only from the state register so out_ready never reaches it
    always_comb begin
        in_ready  = (state_q != FILL_FULL);
        out_valid = (state_q != FILL_EMPTY);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_sum   = ent_q[head_q].sum;
        out_flags = ent_q[head_q].flags;
        sticky_v  = sticky_q;
        op_count  = op_count_q;
    end

    // Next fill state, storage write, pointer advance, counter and sticky overflow
    always_comb begin
        state_d    = state_q;
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        op_count_d = op_count_q;
        sticky_d   = sticky_q;

        case (state_q)
            FILL_EMPTY: if (push) state_d = FILL_ONE;
            FILL_ONE: begin
                if (push && !pop)      state_d = FILL_FULL;
                else if (pop && !push) state_d = FILL_EMPTY;
            end
            FILL_FULL:  if (pop) state_d = FILL_ONE;
            default:    state_d = FILL_EMPTY;
        endcase

        // Push-and-pop in ONE lands the new entry exactly where the head moves to
        if (push) begin
            ent_d[tail_q] = '{sum: sum, flags: new_flags};
            tail_d        = tail_q + ptr_t'(1);
            op_count_d    = op_count_q + 8'd1;
        end
        if (pop) begin
            head_d = head_q + ptr_t'(1);
        end

        // A clear in the same cycle as a V=1 push still leaves the bit set
        if (clr_sticky) sticky_d = 1'b0;
        if (push && new_flags[FLAG_V]) sticky_d = 1'b1;
    end

    // State register; reset empties the buffer and zeroes the visible head entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            op_count_q <= 8'd0;
            sticky_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            op_count_q <= op_count_d;
            sticky_q   <= sticky_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// tb/tb_addsub_result_stage.sv - self-checking bench for addsub_result_stage
module tb_addsub_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] sum;
    logic       carry_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic [3:0] out_flags;
    logic       sticky_v;
    logic       clr_sticky;
    logic [7:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    int         m_cnt    = 0;
    bit         m_sticky = 1'b0;
    bit         m_zero   = 1'b1;

    always #5 clk = ~clk;

    addsub_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (a),
        .B          (b),
        .sel        (sel),
        .sum        (sum),
        .carry_out  (carry_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_flags  (out_flags),
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky),
        .op_count   (op_count)
    );

    function automatic logic [3:0] ref_flags(input logic [3:0] fa, input logic [3:0] fb,
                                             input logic fsel, input logic [3:0] fsum,
                                             input logic fco);
        int  opb;
        bit  a_neg, b_neg, r_neg, n, z, v;
        opb   = fsel ? (15 - int'(fb)) : int'(fb);
        a_neg = $signed(fa) < 0;
        b_neg = opb >= 8;
        r_neg = $signed(fsum) < 0;
        n     = r_neg;
        z     = (fsum == 4'd0);
        v     = (a_neg == b_neg) && (r_neg != a_neg);
        return {n, z, fco, v};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("sticky_v", 32'(sticky_v), 32'(m_sticky));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        if (mq.size() > 0) begin
            chk("out_sum", 32'(out_sum), 32'(mq[0][7:4]));
            chk("out_flags", 32'(out_flags), 32'(mq[0][3:0]));
        end else if (m_zero) begin
            chk("out_sum_zero", 32'(out_sum), 32'd0);
            chk("out_flags_zero", 32'(out_flags), 32'd0);
        end
    endtask

    task automatic step();
        bit         m_push, m_pop;
        logic [3:0] f;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_cnt    = 0;
            m_sticky = 1'b0;
            m_zero   = 1'b1;
        end else begin
            m_push = in_valid && (mq.size() < 2);
            m_pop  = out_ready && (mq.size() > 0);
            f      = ref_flags(a, b, sel, sum, carry_out);
            if (m_pop) mq.delete(0);
            if (m_push) begin
                mq.push_back({sum, f});
                m_cnt  = (m_cnt + 1) % 256;
                m_zero = 1'b0;
            end
            if (clr_sticky) m_sticky = 1'b0;
            if (m_push && f[0]) m_sticky = 1'b1;
        end
        @(negedge clk);
        compare();
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                          input logic isel, input logic [3:0] isum, input logic ico);
        in_valid  = v;
        a         = ia;
        b         = ib;
        sel       = isel;
        sum       = isum;
        carry_out = ico;
    endtask

    task automatic rand_in(input logic v);
        set_in(v, 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        set_in(1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_op_count", 32'(op_count), 32'd0);
        chk("reset_sticky", 32'(sticky_v), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;

        // Add with signed overflow: 7 + 1
        set_in(1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
        step();
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("add_out_sum", 32'(out_sum), 32'h8);
        chk("add_out_flags", 32'(out_flags), 32'b1001);
        chk("add_sticky", 32'(sticky_v), 32'd1);
        chk("add_op_count", 32'(op_count), 32'd1);
        out_ready  = 1'b1;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("clr_sticky_only", 32'(sticky_v), 32'd0);

        // Subtract 3-3, then 2-5 arriving while ONE with a pop on the same edge
        set_in(1'b1, 4'h3, 4'h3, 1'b1, 4'h0, 1'b1);
        step();
        chk("sub_zero_flags", 32'(out_flags), 32'b0110);
        set_in(1'b1, 4'h2, 4'h5, 1'b1, 4'hD, 1'b0);
        step();
        chk("pushpop_valid", 32'(out_valid), 32'd1);
        chk("pushpop_sum", 32'(out_sum), 32'hD);
        chk("sub_neg_flags", 32'(out_flags), 32'b1000);
        chk("pushpop_count", 32'(op_count), 32'd3);
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        step();

        // Backpressure with three back-to-back pushes
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        set_in(1'b1, 4'h0, 4'h1, 1'b0, 4'h1, 1'b0);
        step();
        set_in(1'b1, 4'h0, 4'h2, 1'b0, 4'h2, 1'b0);
        step();
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        set_in(1'b1, 4'h0, 4'h3, 1'b0, 4'h3, 1'b0);
        step();
        chk("bp_op_count", 32'(op_count), 32'd2);
        chk("bp_head_stable", 32'(out_sum), 32'h1);
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        out_ready = 1'b1;
        step();
        chk("bp_drain_second", 32'(out_sum), 32'h2);
        step();
        chk("bp_drain_empty", 32'(out_valid), 32'd0);

        // Reset while FULL, with a push and pop offered in the reset cycle
        out_ready = 1'b0;
        set_in(1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
        step();
        step();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        chk("rstfull_out_valid", 32'(out_valid), 32'd0);
        chk("rstfull_in_ready", 32'(in_ready), 32'd1);
        chk("rstfull_op_count", 32'(op_count), 32'd0);
        chk("rstfull_out_flags", 32'(out_flags), 32'd0);

        // Counter wrap after 256 pushes, then set-wins sticky
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            rand_in(1'b1);
            step();
        end
        chk("wrap_op_count", 32'(op_count), 32'd0);
        clr_sticky = 1'b1;
        set_in(1'b1, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0);
        step();
        chk("set_wins_sticky", 32'(sticky_v), 32'd1);
        set_in(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
        step();
        chk("clear_alone_sticky", 32'(sticky_v), 32'd0);
        clr_sticky = 1'b0;

        // Randomised traffic with occasional reset and sticky clear
        for (int i = 0; i < 3000; i++) begin
            rand_in(1'($urandom_range(0, 3) != 0));
            out_ready  = 1'($urandom_range(0, 2) != 0);
            clr_sticky = ($urandom_range(0, 15) == 0);
            rst_n      = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
